umi_regmaster: RTL and testbench

- Host-side UMI requester that sits directly upstream of the register-array device.
- Converts a simple single-outstanding register strobe interface (CPU/JTAG/test bridge) into single-word UMI read/write/posted requests.
- Waits for and checks the matching response, with an optional timeout.
- Returns read data and a 2-bit error status to the host.

---
 rtl/umi_pkg.sv | 28 ++
 rtl/umi_cmd_pack.sv | 25 ++
 rtl/umi_regmaster.sv | 171 +++++++++++++++++
 tb/tb_umi_regmaster.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/umi_pkg.sv
// UMI opcode constants, command field offsets, completion codes and requester FSM states.
// Shared by UMI requesters and the command packer.
package umi_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

  localparam int CMD_OPCODE_LSB = 0;
  localparam int CMD_SIZE_LSB   = 5;
  localparam int CMD_LEN_LSB    = 8;
  localparam int CMD_EOM_BIT    = 22;
  localparam int CMD_ERR_LSB    = 25;
  localparam int CMD_HOSTID_LSB = 27;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } rm_state_t;

endpackage

// File: rtl/umi_cmd_pack.sv
// Packs opcode/size/len/eom/hostid into a UMI command word; every other bit is zero.
// Purely combinational, no latency, no flow control.
module umi_cmd_pack
  import umi_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic [4:0]    i_opcode,
  input  logic [2:0]    i_size,
  input  logic [7:0]    i_len,
  input  logic          i_eom,
  input  logic [4:0]    i_hostid,
  output logic [CW-1:0] o_cmd
);

  always_comb begin
    o_cmd                              = '0;
    o_cmd[CMD_OPCODE_LSB +: 5]         = i_opcode;
    o_cmd[CMD_SIZE_LSB +: 3]           = i_size;
    o_cmd[CMD_LEN_LSB +: 8]            = i_len;
    o_cmd[CMD_EOM_BIT]                 = i_eom;
    o_cmd[CMD_HOSTID_LSB +: 5]         = i_hostid;
  end

endmodule

// File: rtl/umi_regmaster.sv
// Single-outstanding host register strobe to UMI read/write/posted requester with response check and timeout.
// Request issued the cycle after accept, held until udev_req_ready; response always accepted.
module umi_regmaster
  import umi_pkg::*;
#(
  parameter int          CW      = 32,
  parameter int          AW      = 64,
  parameter int          DW      = 64,
  parameter int          RW      = 32,
  parameter logic [4:0]  HOSTID  = 5'd0,
  parameter logic [AW-1:0] SRCADDR = '0,
  parameter int          TOW     = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          host_valid,
  input  logic          host_write,
  input  logic          host_posted,
  input  logic [AW-1:0] host_addr,
  input  logic [RW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_done,
  output logic [RW-1:0] host_rdata,
  output logic [1:0]    host_err,
  output logic          host_stray,
  output logic          udev_req_valid,
  output logic [CW-1:0] udev_req_cmd,
  output logic [AW-1:0] udev_req_dstaddr,
  output logic [AW-1:0] udev_req_srcaddr,
  output logic [DW-1:0] udev_req_data,
  input  logic          udev_req_ready,
  input  logic          udev_resp_valid,
  input  logic [CW-1:0] udev_resp_cmd,
  input  logic [AW-1:0] udev_resp_dstaddr,
  input  logic [AW-1:0] udev_resp_srcaddr,
  input  logic [DW-1:0] udev_resp_data,
  output logic          udev_resp_ready
);

  localparam int         TW   = (TOW > 0) ? TOW : 1;
  localparam logic [2:0] SIZE = 3'($clog2(RW / 8));

  rm_state_t     r_state;
  logic          r_write;
  logic          r_posted;
  logic [TW-1:0] r_tmo;
  logic          r_done;
  logic [RW-1:0] r_rdata;
  logic [1:0]    r_err;
  logic          r_stray;
  logic          r_req_vld;
  logic [CW-1:0] r_req_cmd;
  logic [AW-1:0] r_req_dst;
  logic [AW-1:0] r_req_src;
  logic [DW-1:0] r_req_dat;
  logic          r_resp_rdy;

  logic [4:0]    w_opcode;
  logic [CW-1:0] w_cmd;
  logic [4:0]    w_exp_op;
  logic          w_resp_match;
  logic [TW-1:0] w_tmo_nxt;
  logic          w_tmo_hit;
  logic          w_unused;

  // host_posted only matters for writes
  assign w_opcode = !host_write ? UMI_REQ_READ :
                    host_posted ? UMI_REQ_POSTED : UMI_REQ_WRITE;

  umi_cmd_pack #(.CW(CW)) u_cmd_pack (
    .i_opcode (w_opcode),
    .i_size   (SIZE),
    .i_len    (8'd0),
    .i_eom    (1'b1),
    .i_hostid (HOSTID),
    .o_cmd    (w_cmd)
  );

  assign w_exp_op     = r_write ? UMI_RESP_WRITE : UMI_RESP_READ;
  assign w_resp_match = (udev_resp_cmd[CMD_OPCODE_LSB +: 5] == w_exp_op) &&
                        (udev_resp_dstaddr == SRCADDR) &&
                        (udev_resp_cmd[CMD_HOSTID_LSB +: 5] == HOSTID);

  // Timeout fires on the cycle the counter saturates, unless a response arrives then.
  assign w_tmo_nxt = r_tmo + 1'b1;
  assign w_tmo_hit = (TOW > 0) && (&w_tmo_nxt);

  assign w_unused = ^{udev_resp_srcaddr, udev_resp_data, udev_resp_cmd};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_posted   <= 1'b0;
      r_tmo      <= '0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_err      <= ERR_OK;
      r_stray    <= 1'b0;
      r_req_vld  <= 1'b0;
      r_req_cmd  <= '0;
      r_req_dst  <= '0;
      r_req_src  <= '0;
      r_req_dat  <= '0;
      r_resp_rdy <= 1'b0;
    end else begin
      r_resp_rdy <= 1'b1;
      r_stray    <= udev_resp_valid && r_resp_rdy && (r_state != ST_WAIT);
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (host_valid) begin
            r_write   <= host_write;
            r_posted  <= host_write && host_posted;
            r_req_vld <= 1'b1;
            r_req_cmd <= w_cmd;
            r_req_dst <= host_addr;
            r_req_src <= SRCADDR;
            r_req_dat <= host_write ? DW'(host_wdata) : '0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (udev_req_ready) begin
            r_req_vld <= 1'b0;
            r_tmo     <= '0;
            if (r_posted) begin
              r_err   <= ERR_OK;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (udev_resp_valid) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
            if (w_resp_match) begin
              r_err <= udev_resp_cmd[CMD_ERR_LSB +: 2];
              if (!r_write) r_rdata <= udev_resp_data[RW-1:0];
            end else begin
              r_err <= ERR_TMO;
            end
          end else if (w_tmo_hit) begin
            r_err   <= ERR_TMO;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_tmo <= w_tmo_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign host_ready       = (r_state == ST_IDLE);
  assign host_done        = r_done;
  assign host_rdata       = r_rdata;
  assign host_err         = r_err;
  assign host_stray       = r_stray;
  assign udev_req_valid   = r_req_vld;
  assign udev_req_cmd     = r_req_cmd;
  assign udev_req_dstaddr = r_req_dst;
  assign udev_req_srcaddr = r_req_src;
  assign udev_req_data    = r_req_dat;
  assign udev_resp_ready  = r_resp_rdy;

endmodule

// File: tb/tb_umi_regmaster.sv
// Directed bench for umi_regmaster: write/read/posted/timeout/mismatch/stray/reset scenarios.
module tb_umi_regmaster;

  localparam logic [4:0]  HID  = 5'h03;
  localparam logic [63:0] SRC  = 64'h100;
  localparam logic [31:0] CMD_WR   = 32'h1840_0043;
  localparam logic [31:0] CMD_RD   = 32'h1840_0041;
  localparam logic [31:0] CMD_PW   = 32'h1840_0045;
  localparam logic [31:0] RSP_WR   = 32'h1800_0004;
  localparam logic [31:0] RSP_RD   = 32'h1800_0002;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        host_valid = 0, host_write = 0, host_posted = 0;
  logic [63:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ready, host_done, host_stray;
  logic [31:0] host_rdata;
  logic [1:0]  host_err;
  logic        udev_req_valid;
  logic [31:0] udev_req_cmd;
  logic [63:0] udev_req_dstaddr, udev_req_srcaddr, udev_req_data;
  logic        udev_req_ready = 1'b1;
  logic        udev_resp_valid = 1'b0;
  logic [31:0] udev_resp_cmd = '0;
  logic [63:0] udev_resp_dstaddr = '0, udev_resp_srcaddr = '0, udev_resp_data = '0;
  logic        udev_resp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  umi_regmaster #(.RW(32), .HOSTID(HID), .SRCADDR(SRC), .TOW(4)) dut (
    .clk(clk), .nreset(nreset),
    .host_valid(host_valid), .host_write(host_write), .host_posted(host_posted),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_done(host_done), .host_rdata(host_rdata),
    .host_err(host_err), .host_stray(host_stray),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
    .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
    .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // All driving and sampling happens 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input logic w, input logic p, input logic [63:0] a, input logic [31:0] d);
    host_valid = 1'b1; host_write = w; host_posted = p; host_addr = a; host_wdata = d;
    step();
    host_valid = 1'b0; host_write = 1'b0; host_posted = 1'b0;
  endtask

  task automatic resp(input logic [31:0] c, input logic [63:0] dst, input logic [63:0] d);
    udev_resp_valid = 1'b1; udev_resp_cmd = c; udev_resp_dstaddr = dst; udev_resp_data = d;
    udev_resp_srcaddr = 64'h10;
    step();
    udev_resp_valid = 1'b0;
  endtask

  initial begin
    int  n;
    logic stable;

    // reset state
    #12;
    chk("rst_req_valid", udev_req_valid, 0);
    chk("rst_req_payload", |{udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data}, 0);
    chk("rst_host_outs", {host_done, host_err, host_rdata, host_stray}, 0);
    chk("rst_resp_ready", udev_resp_ready, 0);
    @(negedge clk); nreset = 1'b1;
    step();
    chk("resp_ready_after_rst", udev_resp_ready, 1);
    chk("host_ready_idle", host_ready, 1);

    // write 0xDEADBEEF to 0x10
    host_req(1, 0, 64'h10, 32'hDEADBEEF);
    chk("wr_req_valid", udev_req_valid, 1);
    chk("wr_cmd", udev_req_cmd, CMD_WR);
    chk("wr_dst", udev_req_dstaddr, 64'h10);
    chk("wr_src", udev_req_srcaddr, SRC);
    chk("wr_data", udev_req_data, 64'h0000_0000_DEAD_BEEF);
    chk("wr_host_ready_busy", host_ready, 0);
    step();
    chk("wr_valid_drop", udev_req_valid, 0);
    step();
    resp(RSP_WR, SRC, '0);
    chk("wr_done", host_done, 1);
    chk("wr_err", host_err, 2'b00);
    step();
    chk("wr_done_pulse", host_done, 0);
    chk("wr_idle", host_ready, 1);

    // read 0x10, err=01
    host_req(0, 1, 64'h10, 32'h1234_5678);
    chk("rd_cmd", udev_req_cmd, CMD_RD);
    chk("rd_data_zero", udev_req_data, 0);
    step();
    resp(RSP_RD | 32'h0200_0000, SRC, 64'h1234_5678_CAFE_F00D);
    chk("rd_done", host_done, 1);
    chk("rd_rdata", host_rdata, 32'hCAFEF00D);
    chk("rd_err", host_err, 2'b01);
    step();

    // posted write with 5 cycles of backpressure
    udev_req_ready = 1'b0;
    host_req(1, 1, 64'h20, 32'h55AA);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(udev_req_valid && udev_req_cmd == CMD_PW && udev_req_dstaddr == 64'h20 &&
            udev_req_data == 64'h55AA && !host_done)) stable = 1'b0;
      step();
    end
    udev_req_ready = 1'b1;
    if (!(udev_req_valid && udev_req_cmd == CMD_PW && udev_req_data == 64'h55AA)) stable = 1'b0;
    chk("pw_stable", stable, 1);
    step();
    chk("pw_done", host_done, 1);
    chk("pw_err", host_err, 2'b00);
    chk("pw_valid_drop", udev_req_valid, 0);
    step();
    chk("pw_idle", host_ready, 1);

    // read timeout: 15 WAIT cycles with TOW=4
    host_req(0, 0, 64'h30, '0);
    step();
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (host_done) break;
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_err", host_err, 2'b11);
    chk("tmo_rdata_held", host_rdata, 32'hCAFEF00D);
    step();
    host_req(0, 0, 64'h30, '0);
    step();
    resp(RSP_RD, SRC, 64'h1111_2222);
    chk("post_tmo_rd_done", host_done, 1);
    chk("post_tmo_rd", {host_err, host_rdata}, {2'b00, 32'h1111_2222});
    step();

    // response on the saturating cycle beats the timeout
    host_req(0, 0, 64'h34, '0);
    step();
    for (int i = 0; i < 14; i++) step();
    chk("sat_no_done_yet", host_done, 0);
    resp(RSP_RD, SRC, 64'h3333_4444);
    chk("sat_done", host_done, 1);
    chk("sat_resp_wins", {host_err, host_rdata}, {2'b00, 32'h3333_4444});
    step();

    // wrong opcode to a read
    host_req(0, 0, 64'h40, '0);
    step();
    resp(RSP_WR, SRC, 64'h9999_9999);
    chk("badop_err", host_err, 2'b11);
    chk("badop_rdata_held", host_rdata, 32'h3333_4444);
    step();
    // wrong dstaddr to a write
    host_req(1, 0, 64'h44, 32'h1);
    step();
    resp(RSP_WR, SRC + 64'h8, '0);
    chk("baddst_err", host_err, 2'b11);
    step();

    // stray response in IDLE
    resp(RSP_RD, SRC, 64'h7777);
    chk("stray_pulse", host_stray, 1);
    chk("stray_idle", host_ready, 1);
    chk("stray_rdata_held", host_rdata, 32'h3333_4444);
    step();
    chk("stray_pulse_end", host_stray, 0);

    // reset while in WAIT
    host_req(0, 0, 64'h50, '0);
    step();
    step();
    nreset = 1'b0;
    #1;
    chk("rst_wait_outs", |{host_done, host_err, host_rdata, host_stray, udev_req_valid,
                            udev_req_cmd, udev_req_dstaddr, udev_req_data, udev_resp_ready}, 0);
    resp(RSP_RD, SRC, 64'h5);
    chk("rst_no_done", host_done, 0);
    @(negedge clk); nreset = 1'b1;
    step();
    chk("rst_rel_ready", host_ready, 1);
    host_req(0, 0, 64'h50, '0);
    step();
    resp(RSP_RD, SRC, 64'hABCD_0123);
    chk("rst_new_rd_done", host_done, 1);
    chk("rst_new_rd", {host_err, host_rdata}, {2'b00, 32'hABCD_0123});
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
